// File: rtl/lader_pkg.sv
// Shared state codes and handshake phases for the program loader.
package lader_pkg;

  localparam int ZUSTAND_BREITE = 3;

  typedef enum logic [ZUSTAND_BREITE-1:0] {
    LEERLAUF          = 3'd0,
    GROESSE_ANFORDERN = 3'd1,
    GROESSE_WARTEN    = 3'd2,
    WORT_ANFORDERN    = 3'd3,
    WORT_WARTEN       = 3'd4,
    SCHREIBEN         = 3'd5,
    FERTIG            = 3'd6,
    FEHLER            = 3'd7
  } zustand_t;

  typedef enum logic [1:0] {
    BEREIT     = 2'd0,
    WARTE_HOCH = 2'd1,
    WARTE_TIEF = 2'd2
  } anfrage_phase_t;

endpackage

// File: rtl/sd_wort_anfrage.sv
// One SD word read: request pulse, wait for busy to rise (with timeout), then fall.
module sd_wort_anfrage
  import lader_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic Anfrage,
  input  logic SDBusy,
  output logic SDLesen,
  output logic Gueltig,
  output logic Timeout
);

  localparam int ZW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  // Loaded with BUSY_TIMEOUT-1 so Timeout fires BUSY_TIMEOUT edges after the request edge.
  localparam logic [ZW-1:0] START_WERT = ZW'(BUSY_TIMEOUT - 1);

  anfrage_phase_t  phase;
  logic [ZW-1:0]   zaehler;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      phase   <= BEREIT;
      zaehler <= '0;
      SDLesen <= 1'b0;
    end else begin
      SDLesen <= 1'b0;
      case (phase)
        BEREIT: begin
          if (Anfrage && !SDBusy) begin
            SDLesen <= 1'b1;
            zaehler <= START_WERT;
            phase   <= WARTE_HOCH;
          end
        end
        WARTE_HOCH: begin
          if (SDBusy)
            phase <= WARTE_TIEF;
          else if (zaehler == '0)
            phase <= BEREIT;
          else
            zaehler <= zaehler - 1'b1;
        end
        WARTE_TIEF: begin
          if (!SDBusy)
            phase <= BEREIT;
        end
        default: phase <= BEREIT;
      endcase
    end
  end

  assign Gueltig = (phase == WARTE_TIEF) && !SDBusy;
  assign Timeout = (phase == WARTE_HOCH) && !SDBusy && (zaehler == '0);

endmodule

// File: rtl/programm_lader.sv
// Boot loader: reads a size header and N words from SD and writes them to RAM 0..N-1.
// LEERLAUF idle | *_ANFORDERN request read | *_WARTEN await word | SCHREIBEN RAM write | FERTIG/FEHLER terminal
module programm_lader
  import lader_pkg::*;
#(
  parameter int RAM_WORTE       = 1024,
  parameter int SD_STARTADRESSE = 0,
  parameter int BUSY_TIMEOUT    = 255
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Start,
  output logic [31:0] SDAdresse,
  output logic        SDLesen,
  input  logic [31:0] SDDaten,
  input  logic        SDBusy,
  output logic [15:0] RAMAdresse,
  output logic [31:0] RAMDaten,
  output logic        RAMSchreiben,
  output logic        CPUReset,
  output logic        Fertig,
  output logic        Fehler,
  output logic [2:0]  Zustand
);

  logic [1:0]  rstSync;
  logic        laufFrei;
  zustand_t    zustand;
  logic [31:0] restAnzahl;
  logic        anfrage;
  logic        gueltig;
  logic        timeout;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) rstSync <= 2'b00;
    else          rstSync <= {rstSync[0], 1'b1};
  end
  assign laufFrei = rstSync[1];

  assign anfrage = (zustand == GROESSE_ANFORDERN) || (zustand == WORT_ANFORDERN);
  assign Zustand = zustand;

  sd_wort_anfrage #(
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) uAnfrage (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Anfrage (anfrage),
    .SDBusy  (SDBusy),
    .SDLesen (SDLesen),
    .Gueltig (gueltig),
    .Timeout (timeout)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      zustand      <= LEERLAUF;
      SDAdresse    <= '0;
      RAMAdresse   <= '0;
      RAMDaten     <= '0;
      RAMSchreiben <= 1'b0;
      CPUReset     <= 1'b1;
      Fertig       <= 1'b0;
      Fehler       <= 1'b0;
      restAnzahl   <= '0;
    end else begin
      RAMSchreiben <= 1'b0;
      case (zustand)
        LEERLAUF: begin
          if (laufFrei && Start) begin
            SDAdresse <= 32'(SD_STARTADRESSE);
            zustand   <= GROESSE_ANFORDERN;
          end
        end
        GROESSE_ANFORDERN: if (!SDBusy) zustand <= GROESSE_WARTEN;
        GROESSE_WARTEN: begin
          if (timeout) begin
            zustand <= FEHLER;
            Fehler  <= 1'b1;
          end else if (gueltig) begin
            restAnzahl <= SDDaten;
            if (SDDaten == 32'd0) begin
              zustand  <= FERTIG;
              Fertig   <= 1'b1;
              CPUReset <= 1'b0;
            end else if (SDDaten > 32'(RAM_WORTE)) begin
              zustand <= FEHLER;
              Fehler  <= 1'b1;
            end else begin
              SDAdresse  <= 32'(SD_STARTADRESSE) + 32'd1;
              RAMAdresse <= '0;
              zustand    <= WORT_ANFORDERN;
            end
          end
        end
        WORT_ANFORDERN: if (!SDBusy) zustand <= WORT_WARTEN;
        WORT_WARTEN: begin
          if (timeout) begin
            zustand <= FEHLER;
            Fehler  <= 1'b1;
          end else if (gueltig) begin
            RAMDaten     <= SDDaten;
            RAMSchreiben <= 1'b1;
            zustand      <= SCHREIBEN;
          end
        end
        SCHREIBEN: begin
          restAnzahl <= restAnzahl - 32'd1;
          if (restAnzahl == 32'd1) begin
            zustand  <= FERTIG;
            Fertig   <= 1'b1;
            CPUReset <= 1'b0;
          end else begin
            SDAdresse  <= SDAdresse + 32'd1;
            RAMAdresse <= RAMAdresse + 16'd1;
            zustand    <= WORT_ANFORDERN;
          end
        end
        FERTIG, FEHLER: ;
        default: zustand <= LEERLAUF;
      endcase
    end
  end

endmodule

// File: tb/tb_programm_lader.sv
// Directed bench for programm_lader with a behavioural SD reader and RAM write monitor.
module tb_programm_lader;

  localparam int BT = 255;

  logic        Clock;
  logic        Reset_n;
  logic        Start;
  logic [31:0] SDAdresse;
  logic        SDLesen;
  logic [31:0] SDDaten;
  logic        SDBusy;
  logic [15:0] RAMAdresse;
  logic [31:0] RAMDaten;
  logic        RAMSchreiben;
  logic        CPUReset;
  logic        Fertig;
  logic        Fehler;
  logic [2:0]  Zustand;

  programm_lader dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .Start        (Start),
    .SDAdresse    (SDAdresse),
    .SDLesen      (SDLesen),
    .SDDaten      (SDDaten),
    .SDBusy       (SDBusy),
    .RAMAdresse   (RAMAdresse),
    .RAMDaten     (RAMDaten),
    .RAMSchreiben (RAMSchreiben),
    .CPUReset     (CPUReset),
    .Fertig       (Fertig),
    .Fehler       (Fehler),
    .Zustand      (Zustand)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  // SD reader model controls
  logic [31:0] sdHeader;
  int          busyLen;
  logic        ausfallAktiv;
  logic [31:0] ausfallAdr;
  logic        vorabBusy;
  logic        busyModel;
  assign SDBusy = vorabBusy | busyModel;

  function automatic logic [31:0] sdWort(input logic [31:0] adr);
    return (adr == 32'd0) ? sdHeader : (32'hA000_0000 | adr);
  endfunction

  int zyklus = 0;
  initial forever begin
    @(posedge Clock);
    zyklus = zyklus + 1;
  end

  initial begin : sd_modell
    logic        pending;
    int          busyCnt;
    logic [31:0] modelAdr;
    busyModel = 1'b0;
    SDDaten   = 32'd0;
    pending   = 1'b0;
    busyCnt   = 0;
    modelAdr  = 32'd0;
    forever begin
      @(negedge Clock);
      if (!Reset_n) begin
        busyModel = 1'b0;
        pending   = 1'b0;
        busyCnt   = 0;
      end else begin
        if (pending) begin
          pending = 1'b0;
          if (!(ausfallAktiv && modelAdr == ausfallAdr)) begin
            busyModel = 1'b1;
            busyCnt   = busyLen;
          end
        end else if (busyCnt > 0) begin
          busyCnt = busyCnt - 1;
          if (busyCnt == 0) begin
            busyModel = 1'b0;
            SDDaten   = sdWort(modelAdr);
          end
        end
        if (SDLesen) begin
          pending  = 1'b1;
          modelAdr = SDAdresse;
        end
      end
    end
  end

  logic [15:0] wrA[$];
  logic [31:0] wrD[$];
  int          lesenZ[$];
  logic [31:0] lesenA[$];
  int          ueberlapp = 0;

  initial forever begin
    @(negedge Clock);
    if (Reset_n) begin
      if (RAMSchreiben) begin
        wrA.push_back(RAMAdresse);
        wrD.push_back(RAMDaten);
      end
      if (SDLesen) begin
        lesenZ.push_back(zyklus);
        lesenA.push_back(SDAdresse);
      end
      if (SDLesen && RAMSchreiben) ueberlapp = ueberlapp + 1;
    end
  end

  task automatic pruefe(input string name, input logic [31:0] ist, input logic [31:0] soll);
    checks = checks + 1;
    if (ist !== soll) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, ist, soll);
    end
  endtask

  task automatic resetDut();
    Reset_n = 1'b0;
    Start   = 1'b0;
    repeat (3) @(negedge Clock);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clock);
  endtask

  // k = number of clock edges after the Start-sampling edge until Fertig/Fehler is visible
  task automatic laden(input bit toggle, output int k, output bit ok, output int zEnde);
    Start = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    k  = 0;
    ok = 1'b0;
    while (!ok && k < 20000) begin
      @(posedge Clock);
      k = k + 1;
      @(negedge Clock);
      if (toggle) Start = ~Start;
      if (Fertig || Fehler) ok = 1'b1;
    end
    Start = 1'b0;
    zEnde = zyklus;
  endtask

  typedef struct {
    int n;
    int busy;
    bit ausfall;
    bit toggle;
    bit vorab;
    bit expFertig;
    int expWrites;
    int expZyklen;
  } vektor_t;

  vektor_t tabelle[7];

  initial begin : haupt
    int  k;
    bit  ok;
    int  zEnde;
    int  basisW;
    int  basisL;
    int  basisU;
    int  nW;
    bit  gefunden;
    logic [2:0] zAlt;

    Reset_n      = 1'b0;
    Start        = 1'b0;
    vorabBusy    = 1'b0;
    ausfallAktiv = 1'b0;
    ausfallAdr   = 32'd1;
    busyLen      = 5;
    sdHeader     = 32'd0;

    //            n     busy ausf tog vorab fertig writes zyklen
    tabelle[0] = '{3,    5,   0,   0,  0,    1,     3,     35};
    tabelle[1] = '{0,    5,   0,   0,  0,    1,     0,     8};
    tabelle[2] = '{1025, 2,   0,   0,  0,    0,     0,     5};
    tabelle[3] = '{1024, 1,   0,   0,  0,    1,     1024,  5124};
    tabelle[4] = '{3,    5,   0,   1,  1,    1,     3,     35};
    tabelle[5] = '{2,    3,   1,   0,  0,    0,     0,     262};
    tabelle[6] = '{1,    1,   0,   0,  0,    1,     1,     9};

    repeat (2) @(negedge Clock);
    pruefe("rst_zustand", 32'(Zustand), 32'd0);
    pruefe("rst_sdlesen", 32'(SDLesen), 32'd0);
    pruefe("rst_ramschreiben", 32'(RAMSchreiben), 32'd0);
    pruefe("rst_sdadresse", SDAdresse, 32'd0);
    pruefe("rst_ramadresse", 32'(RAMAdresse), 32'd0);
    pruefe("rst_ramdaten", RAMDaten, 32'd0);
    pruefe("rst_cpureset", 32'(CPUReset), 32'd1);
    pruefe("rst_fertig", 32'(Fertig), 32'd0);
    pruefe("rst_fehler", 32'(Fehler), 32'd0);

    // Start held through reset release: FSM may only leave LEERLAUF on the third edge
    Start   = 1'b1;
    Reset_n = 1'b1;
    @(negedge Clock);
    pruefe("sync_kante1", 32'(Zustand), 32'd0);
    @(negedge Clock);
    pruefe("sync_kante2", 32'(Zustand), 32'd0);
    @(negedge Clock);
    pruefe("sync_kante3", 32'(Zustand), 32'd1);
    Start = 1'b0;

    for (int i = 0; i < 7; i++) begin
      resetDut();
      sdHeader     = 32'(tabelle[i].n);
      busyLen      = tabelle[i].busy;
      ausfallAktiv = tabelle[i].ausfall;
      if (tabelle[i].vorab) begin
        vorabBusy = 1'b1;
        repeat (4) @(negedge Clock);
        pruefe("vorab_zustand", 32'(Zustand), 32'd0);
        vorabBusy = 1'b0;
        @(negedge Clock);
      end
      basisW = wrA.size();
      basisL = lesenZ.size();
      basisU = ueberlapp;
      laden(tabelle[i].toggle, k, ok, zEnde);
      pruefe("fertig_oder_fehler", 32'(ok), 32'd1);
      pruefe("fertig", 32'(Fertig), 32'(tabelle[i].expFertig));
      pruefe("fehler", 32'(Fehler), 32'(!tabelle[i].expFertig));
      pruefe("cpureset", 32'(CPUReset), 32'(!tabelle[i].expFertig));
      pruefe("zustand_ende", 32'(Zustand), tabelle[i].expFertig ? 32'd6 : 32'd7);
      pruefe("latenz", k, tabelle[i].expZyklen);
      pruefe("anzahl_writes", wrA.size() - basisW, tabelle[i].expWrites);
      pruefe("ueberlappung", ueberlapp - basisU, 32'd0);
      if (lesenA.size() > basisL) pruefe("erste_sdadresse", lesenA[basisL], 32'd0);
      else pruefe("anzahl_lesen", lesenA.size() - basisL, 32'd1);
      nW = wrA.size() - basisW;
      if (nW > tabelle[i].expWrites) nW = tabelle[i].expWrites;
      for (int j = 0; j < nW; j++) begin
        pruefe("wr_adresse", 32'(wrA[basisW + j]), j);
        pruefe("wr_daten", wrD[basisW + j], 32'hA000_0000 | 32'(j + 1));
      end
      if (tabelle[i].ausfall) begin
        if (lesenZ.size() >= basisL + 2)
          pruefe("timeout_abstand", zEnde - lesenZ[basisL + 1], BT);
        else
          pruefe("anzahl_lesen_timeout", lesenZ.size() - basisL, 32'd2);
      end
      zAlt = Zustand;
      Start = 1'b1;
      repeat (3) @(negedge Clock);
      Start = 1'b0;
      repeat (2) @(negedge Clock);
      pruefe("terminal", 32'(Zustand), 32'(zAlt));
    end

    // Reset in the middle of writing word 2 of 4, then a fresh load
    resetDut();
    sdHeader     = 32'd4;
    busyLen      = 2;
    ausfallAktiv = 1'b0;
    Start = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    gefunden = 1'b0;
    for (int i = 0; i < 500 && !gefunden; i++) begin
      @(negedge Clock);
      if (RAMSchreiben && RAMAdresse == 16'd1) gefunden = 1'b1;
    end
    pruefe("abbruch_wort2_erreicht", 32'(gefunden), 32'd1);
    Reset_n = 1'b0;
    #1;
    pruefe("abbruch_zustand", 32'(Zustand), 32'd0);
    pruefe("abbruch_ramschreiben", 32'(RAMSchreiben), 32'd0);
    pruefe("abbruch_sdadresse", SDAdresse, 32'd0);
    pruefe("abbruch_ramadresse", 32'(RAMAdresse), 32'd0);
    pruefe("abbruch_cpureset", 32'(CPUReset), 32'd1);
    basisW = wrA.size();
    repeat (5) @(negedge Clock);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clock);
    pruefe("abbruch_keine_writes", wrA.size() - basisW, 32'd0);
    pruefe("abbruch_wartet_start", 32'(Zustand), 32'd0);
    basisL = lesenA.size();
    laden(1'b0, k, ok, zEnde);
    pruefe("neustart_fertig", 32'(Fertig), 32'd1);
    pruefe("neustart_latenz", k, 32'd29);
    pruefe("neustart_writes", wrA.size() - basisW, 32'd4);
    if (lesenA.size() > basisL) pruefe("neustart_sdadresse", lesenA[basisL], 32'd0);
    else pruefe("neustart_lesen", lesenA.size() - basisL, 32'd1);
    nW = wrA.size() - basisW;
    if (nW > 4) nW = 4;
    for (int j = 0; j < nW; j++) begin
      pruefe("neustart_wr_adresse", 32'(wrA[basisW + j]), j);
      pruefe("neustart_wr_daten", wrD[basisW + j], 32'hA000_0000 | 32'(j + 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
